// File: rtl/switch_event_ctrl.sv
// switch_event_ctrl: debounces 16 switches, tracks
// settled changes and reports them over valid/ready.
module switch_event_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] sw,
  output logic [31:0] state,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [15:0] evt_data,
  output logic [15:0] evt_mask,
  output logic        evt_overrun,
  output logic [15:0] chg_count
);

  localparam logic [CNT_W-1:0] LP_DEB =
    CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic {
    IDLE,
    PEND
  } st_t;

  st_t              r_st;
  st_t              w_st_nx;
  logic [15:0]      r_s1;
  logic [15:0]      r_s2;
  logic [15:0]      r_cand;
  logic [15:0]      r_stable;
  logic [15:0]      r_reported;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_chg_since;
  logic [15:0]      r_chg_count;
  logic [15:0]      r_evt_data;
  logic [15:0]      r_evt_mask;
  logic             r_evt_ovr;
  logic             r_evt_valid;
  logic             w_new;
  logic             w_capture;
  logic             w_accept;

  // stable takes a new, different value this cycle
  assign w_new = (r_cnt == LP_DEB) &&
                 (r_cand != r_stable);

  // synchroniser plus shared-counter debounce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1     <= '0;
      r_s2     <= '0;
      r_cand   <= '0;
      r_cnt    <= '0;
      r_stable <= '0;
    end else begin
      r_s1 <= sw;
      r_s2 <= r_s1;
      if (r_s2 != r_cand) begin
        r_cand <= r_s2;
        r_cnt  <= '0;
      end else if (r_cnt < LP_DEB) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (w_new) r_stable <= r_cand;
    end
  end

  // change counters; a change landing on the capture
  // cycle belongs to the next event
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chg_count <= '0;
      r_chg_since <= '0;
    end else begin
      if (w_new) r_chg_count <= r_chg_count + 16'd1;
      if (w_capture) begin
        r_chg_since <= w_new ? 2'd1 : 2'd0;
      end else if (w_new && r_chg_since != 2'd2) begin
        r_chg_since <= r_chg_since + 2'd1;
      end
    end
  end

  // event FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_st <= IDLE;
    else        r_st <= w_st_nx;
  end

  // event FSM next state and strobes
  always_comb begin
    w_st_nx   = r_st;
    w_capture = 1'b0;
    w_accept  = 1'b0;
    unique case (r_st)
      IDLE: begin
        if (r_stable != r_reported) begin
          w_capture = 1'b1;
          w_st_nx   = PEND;
        end
      end
      PEND: begin
        if (evt_ready) begin
          w_accept = 1'b1;
          w_st_nx  = IDLE;
        end
      end
      default: w_st_nx = IDLE;
    endcase
  end

  // event payload capture and registered valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_reported  <= '0;
      r_evt_data  <= '0;
      r_evt_mask  <= '0;
      r_evt_ovr   <= 1'b0;
      r_evt_valid <= 1'b0;
    end else begin
      if (w_capture) begin
        r_evt_data  <= r_stable;
        r_evt_mask  <= r_stable ^ r_reported;
        r_reported  <= r_stable;
        r_evt_ovr   <= (r_chg_since >= 2'd2);
        r_evt_valid <= 1'b1;
      end else if (w_accept) begin
        r_evt_valid <= 1'b0;
      end
    end
  end

  assign state       = {16'h0, r_stable};
  assign evt_valid   = r_evt_valid;
  assign evt_data    = r_evt_data;
  assign evt_mask    = r_evt_mask;
  assign evt_overrun = r_evt_ovr;
  assign chg_count   = r_chg_count;

endmodule

// File: tb/tb_switch_event_ctrl.sv
// tb_switch_event_ctrl: random switch stimulus vs a
// history-based debounce model with event scoreboard.
module tb_switch_event_ctrl;

  localparam int DEB = 4;

  logic        clk;
  logic        rst_n;
  logic [15:0] sw;
  logic [31:0] state;
  logic        evt_valid;
  logic        evt_ready;
  logic [15:0] evt_data;
  logic [15:0] evt_mask;
  logic        evt_overrun;
  logic [15:0] chg_count;

  switch_event_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw(sw),
    .state(state),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_data(evt_data),
    .evt_mask(evt_mask),
    .evt_overrun(evt_overrun),
    .chg_count(chg_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] m;
    logic        o;
  } ev_t;

  ev_t q[$];

  int n_cmp = 0;
  int n_bad = 0;
  bit started = 0;

  // reference model state
  logic [15:0] h[0:DEB+3];
  logic [15:0] m_stable;
  logic [15:0] m_rep;
  logic [15:0] m_cnt;
  int          m_since;
  bit          m_pend;
  logic [15:0] m_data;
  logic [15:0] m_mask;
  logic        m_ovr;

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] got,
                     logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, got, exp, $time);
    end
  endtask

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  // model: stable = value seen DEB+1 samples in a row,
  // aged 3 edges; events follow the handshake rules
  always @(posedge clk) begin
    logic [15:0] ns;
    bit          ok;
    if (!rst_n) begin
      for (int i = 0; i <= DEB + 3; i++) h[i] = '0;
      m_stable = '0;
      m_rep    = '0;
      m_cnt    = '0;
      m_since  = 0;
      m_pend   = 0;
      m_data   = '0;
      m_mask   = '0;
      m_ovr    = 0;
      q.delete();
    end else begin
      for (int i = DEB + 3; i > 0; i--) h[i] = h[i-1];
      h[0] = sw;
      ok = 1;
      for (int i = 4; i <= DEB + 3; i++)
        if (h[i] != h[3]) ok = 0;
      ns = ok ? h[3] : m_stable;
      if (m_pend) begin
        if (evt_ready) m_pend = 0;
      end else if (m_stable != m_rep) begin
        m_data  = m_stable;
        m_mask  = m_stable ^ m_rep;
        m_ovr   = (m_since >= 2);
        m_rep   = m_stable;
        m_since = 0;
        m_pend  = 1;
        q.push_back('{m_data, m_mask, m_ovr});
      end
      if (ns != m_stable) begin
        m_cnt    = m_cnt + 16'd1;
        m_since  = m_since + 1;
        m_stable = ns;
      end
    end
  end

  // monitor: compare outputs and pop on handshake
  always @(negedge clk) begin
    ev_t e;
    if (started) begin
      chk("state", state, {16'h0, m_stable});
      chk("chg_count", 32'(chg_count), 32'(m_cnt));
      chk("evt_valid", 32'(evt_valid), 32'(m_pend));
      chk("evt_data", 32'(evt_data), 32'(m_data));
      chk("evt_mask", 32'(evt_mask), 32'(m_mask));
      chk("evt_ovr", 32'(evt_overrun), 32'(m_ovr));
      if (evt_valid && evt_ready && rst_n) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_empty: got event %h want none",
                   evt_data);
        end else begin
          e = q.pop_front();
          chk("sb_data", 32'(evt_data), 32'(e.d));
          chk("sb_mask", 32'(evt_mask), 32'(e.m));
          chk("sb_ovr", 32'(evt_overrun), 32'(e.o));
        end
      end
    end
  end

  initial begin
    rst_n     = 0;
    sw        = '0;
    evt_ready = 0;
    step(2);
    started = 1;
    step(1);
    rst_n = 1;
    step(20);
    // single settled change
    evt_ready = 1;
    sw = 16'h0005;
    step(15);
    // bouncing bit then held
    for (int i = 0; i < 10; i++) begin
      sw[0] = ~sw[0];
      step(2);
    end
    sw[0] = 1'b1;
    step(15);
    // changes piling up while consumer stalls
    evt_ready = 0;
    sw = 16'h0001;
    step(12);
    sw = 16'h0003;
    step(12);
    sw = 16'h0007;
    step(12);
    evt_ready = 1;
    step(12);
    // reset while an event is pending
    evt_ready = 0;
    sw = 16'h0000;
    step(12);
    sw = 16'h0007;
    step(12);
    rst_n = 0;
    step(1);
    rst_n = 1;
    evt_ready = 1;
    step(15);
    // randomized holds, bounces, stalls, resets
    for (int it = 0; it < 2500; it++) begin
      if ($urandom_range(0, 2) == 0)
        sw = sw ^ (16'h1 << $urandom_range(0, 15));
      else if ($urandom_range(0, 3) == 0)
        sw = 16'($urandom);
      evt_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 299) == 0) rst_n = 0;
      step($urandom_range(1, 10));
      rst_n = 1;
    end
    evt_ready = 1;
    step(40);
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
